ts_bus_arbiter: RTL and testbench

Round-robin output-enable sequencer for a shared tri-state bus driven by `N` `ts_pad`-style drivers. Converts per-pad requests into a one-hot (or all-zero) `oe` vector, so at most one pad drives the bus at any time. A programmable turnaround gap separates consecutive tenures, and a hold timer stops any single pad from monopolising the bus. It sits directly upstream of the pad instances: each `oe[i]` feeds pad `i`'s `oe` input, and `$countdrivers` on the bus must never report `multi = 1`.

---
 rtl/ts_bus_pkg.sv | 24 ++
 rtl/rr_pick.sv | 32 +++
 rtl/ts_bus_arbiter.sv | 95 +++++++++
 tb/tb_ts_bus_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_bus_pkg.sv
// Shared types and helpers for the tri-state bus output-enable sequencer.
package ts_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_e;

    localparam int unsigned HOLD_W = 8;

    // Index width for a vector of v entries; never narrower than one bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester strictly after `last`, cyclic ascending.
module rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] masked;

    // Doubling the request vector turns the cyclic search into a linear window last+1..last+N.
    always_comb begin
        dbl    = {req, req};
        masked = '0;
        for (int i = 0; i < 2 * int'(N); i++) begin
            masked[i] = dbl[i] && (i > int'(last)) && (i <= int'(last) + int'(N));
        end
        valid = 1'b0;
        idx   = '0;
        for (int i = 2 * int'(N) - 1; i >= 0; i--) begin
            if (masked[i]) begin
                valid = 1'b1;
                idx   = IDX_W'(i % int'(N));
            end
        end
    end

endmodule

// File: rtl/ts_bus_arbiter.sv
// Round-robin output-enable sequencer keeping at most one tri-state pad driving the bus.
module ts_bus_arbiter
    import ts_bus_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned TURN     = 1,
    localparam int unsigned IDX_W   = clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     done,
    output logic [N-1:0]     oe,
    output logic [IDX_W-1:0] gnt_id,
    output logic             busy,
    output logic             timeout
);

    state_e            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [1:0]        gap_cnt;
    logic [IDX_W-1:0]  last;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic              owner_done;
    logic              owner_drop;
    logic              hold_hit;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign owner_done = done[gnt_id];
    assign owner_drop = !req[gnt_id];
    assign hold_hit   = (hold_cnt == HOLD_W'(HOLD_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            oe       <= '0;
            busy     <= 1'b0;
            gnt_id   <= '0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            last     <= IDX_W'(N - 1);
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_id   <= pick_idx;
                        oe       <= N'(1) << pick_idx;
                        busy     <= 1'b1;
                        hold_cnt <= HOLD_W'(1);
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (owner_done || owner_drop || hold_hit) begin
                        oe      <= '0;
                        busy    <= 1'b0;
                        last    <= gnt_id;
                        // Explicit release or request drop outranks the hold limit.
                        timeout <= hold_hit && !owner_done && !owner_drop;
                        if (TURN == 0) begin
                            state <= IDLE;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= 2'd1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == 2'(TURN)) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ts_bus_arbiter.sv
// Randomized and directed bench for ts_bus_arbiter; two instances with different turnaround gaps.
module tb_ts_bus_arbiter;

    localparam int N  = 4;
    localparam int HM = 8;
    localparam int TA = 1;
    localparam int TB = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] done_a = '0;
    logic [3:0] done_b = '0;
    logic [3:0] oe_a, oe_b;
    logic [1:0] gnt_a, gnt_b;
    logic       busy_a, busy_b, to_a, to_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state per instance: owner (-1 = none), tenure length, gap cycles left.
    int m_owner[2];
    int m_len[2];
    int m_cool[2];
    int m_last[2];
    bit m_to[2];
    int turn_of[2] = '{TA, TB};

    always #5 clk = ~clk;

    ts_bus_arbiter #(.N(N), .HOLD_MAX(HM), .TURN(TA)) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done_a),
        .oe      (oe_a),
        .gnt_id  (gnt_a),
        .busy    (busy_a),
        .timeout (to_a)
    );

    ts_bus_arbiter #(.N(N), .HOLD_MAX(HM), .TURN(TB)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done_b),
        .oe      (oe_b),
        .gnt_id  (gnt_b),
        .busy    (busy_b),
        .timeout (to_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] done_of(input int k);
        return (k == 0) ? done_a : done_b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_len[k]   = 0;
            m_cool[k]  = 0;
            m_last[k]  = N - 1;
            m_to[k]    = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        logic [3:0] d;
        int         o;
        int         c;
        d = done_of(k);
        m_to[k] = 1'b0;
        if (m_owner[k] >= 0) begin
            o = m_owner[k];
            if (d[o] || !req[o] || m_len[k] == HM) begin
                m_to[k]    = (m_len[k] == HM) && !d[o] && req[o];
                m_last[k]  = o;
                m_owner[k] = -1;
                m_cool[k]  = turn_of[k];
            end else begin
                m_len[k]++;
            end
        end else if (m_cool[k] > 0) begin
            m_cool[k]--;
        end else if (req != 4'b0) begin
            for (int i = 1; i <= N; i++) begin
                c = (m_last[k] + i) % N;
                if (req[c]) begin
                    m_owner[k] = c;
                    m_len[k]   = 1;
                    break;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0] exp_oe;
        for (int k = 0; k < 2; k++) begin
            exp_oe = (m_owner[k] >= 0) ? 4'(1 << m_owner[k]) : 4'b0;
            check(k == 0 ? "oe_a" : "oe_b", k == 0 ? oe_a : oe_b, exp_oe);
            check(k == 0 ? "busy_a" : "busy_b", k == 0 ? busy_a : busy_b, m_owner[k] >= 0);
            check(k == 0 ? "timeout_a" : "timeout_b", k == 0 ? to_a : to_b, m_to[k]);
            if (m_owner[k] >= 0) begin
                check(k == 0 ? "gnt_a" : "gnt_b", k == 0 ? gnt_a : gnt_b, m_owner[k]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        compare_all();
    endtask

    task automatic go_idle();
        req    = 4'b0;
        done_a = 4'b0;
        done_b = 4'b0;
        repeat (6) tick();
    endtask

    initial begin
        int   run;
        int   runs;
        int   first_run;
        int   seq[$];
        bit   prev_busy;
        bit   hit_a;
        bit   hit_b;
        bit   found;

        model_reset();
        repeat (2) @(negedge clk);
        check("rst_oe_a", oe_a, 0);
        check("rst_oe_b", oe_b, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_gnt_a", gnt_a, 0);
        check("rst_to_a", to_a, 0);
        check("rst_busy_b", busy_b, 0);

        // First grant goes to index 0
        rst_n = 1'b1;
        req   = 4'b1111;
        tick();
        check("first_oe_a", oe_a, 4'b0001);
        check("first_gnt_a", gnt_a, 0);
        check("first_busy_a", busy_a, 1);

        // Rotation with one-cycle tenures
        prev_busy = busy_a;
        for (int c = 0; c < 30; c++) begin
            done_a = (m_owner[0] >= 0) ? 4'(1 << m_owner[0]) : 4'b0;
            done_b = (m_owner[1] >= 0) ? 4'(1 << m_owner[1]) : 4'b0;
            tick();
            if (busy_a && !prev_busy) seq.push_back(int'(gnt_a));
            prev_busy = busy_a;
        end
        check("rot_count", seq.size() >= 6, 1);
        for (int i = 1; i < seq.size(); i++) begin
            check("rot_order", seq[i], (seq[i-1] + 1) % N);
        end

        // Hold limit on a sole requester
        go_idle();
        req = 4'b0100;
        run = 0;
        runs = 0;
        first_run = -1;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (oe_a[2]) begin
                run++;
            end else if (run > 0) begin
                if (first_run < 0) first_run = run;
                runs++;
                run = 0;
            end
        end
        check("hold_len", first_run, HM);
        check("hold_regrant", runs >= 2, 1);

        // done on the same edge the hold limit is reached
        go_idle();
        req   = 4'b0010;
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int c = 0; c < 40; c++) begin
            done_a = (m_owner[0] == 1 && m_len[0] == HM) ? 4'b0010 : 4'b0;
            done_b = (m_owner[1] == 1 && m_len[1] == HM) ? 4'b0010 : 4'b0;
            tick();
            if (done_a[1]) begin
                hit_a = 1'b1;
                check("simul_to_a", to_a, 0);
                check("simul_oe_a", oe_a, 0);
            end
            if (done_b[1]) begin
                hit_b = 1'b1;
                check("simul_to_b", to_b, 0);
            end
        end
        check("simul_reached_a", hit_a, 1);
        check("simul_reached_b", hit_b, 1);

        // Request rising during a three-cycle gap
        go_idle();
        req   = 4'b0001;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick();
            found = (m_owner[1] == 0);
        end
        check("gap_wait_grant", found, 1);
        done_b = 4'b0001;
        req    = 4'b0000;
        tick();
        check("gap_release_b", oe_b, 0);
        done_b = 4'b0;
        req    = 4'b1000;
        for (int c = 0; c < TB; c++) begin
            tick();
            check("gap_hold_b", oe_b, 0);
        end
        tick();
        check("gap_grant_b", oe_b, 4'b1000);

        // Asynchronous reset mid-tenure
        go_idle();
        req   = 4'b0100;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick();
            found = (oe_a == 4'b0100);
        end
        check("mid_wait_grant", found, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_oe_a", oe_a, 0);
        check("mid_rst_busy_a", busy_a, 0);
        check("mid_rst_oe_b", oe_b, 0);
        model_reset();
        req = 4'b0110;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_oe_a", oe_a, 4'b0010);
        check("post_rst_oe_b", oe_b, 4'b0010);

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            done_a = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            done_b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
